// File: rtl/lampfpu_sqrt_rnd_pkg.sv
// Shared widths, flag positions, S1->S2 stage record and the RNE helper
// for the sqrt/inv-sqrt round-and-pack stage.
package lampfpu_sqrt_rnd_pkg;

  localparam int LAMP_FLOAT_E_DW = 8;
  localparam int LAMP_FLOAT_F_DW = 7;
  localparam int LAMP_FLOAT_DW   = 1 + LAMP_FLOAT_E_DW + LAMP_FLOAT_F_DW;

  localparam int FLAG_OF_IDX = 2;
  localparam int FLAG_UF_IDX = 1;
  localparam int FLAG_NX_IDX = 0;

  // Everything S2 needs once the rounding decision is made
  typedef struct packed {
    logic                       s;
    logic [LAMP_FLOAT_E_DW-1:0] e;
    logic [LAMP_FLOAT_F_DW:0]   m;     // {hidden, frac}
    logic                       inc;
    logic                       nx;
    logic                       of;
    logic                       uf;
    logic                       toRnd;
  } rndStage_t;

  // Round-to-nearest-even: bump on G unless it is an exact tie on an even lsb
  function automatic logic FUNC_rndRNE(input logic lsb, input logic g, input logic stk);
    return g & (stk | lsb);
  endfunction

endpackage

// File: rtl/lampfpu_sqrt_rnd.sv
// Round-and-pack stage behind the lampFPU sqrt / inverse-sqrt unit.
// S1 decides the rounding increment and inexact flag, S2 applies it,
// resolves carry-out / exponent overflow and packs the result.
// Optional feature macro: LAMP_FPU_FLAGS_EN (sticky accumulated flags).
module lampfpu_sqrt_rnd
  import lampfpu_sqrt_rnd_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic                       s_i,
  input  logic [LAMP_FLOAT_E_DW-1:0] e_i,
  input  logic [LAMP_FLOAT_F_DW+4:0] f_i,
  input  logic                       isToRound_i,
  input  logic                       isOverflow_i,
  input  logic                       isUnderflow_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic [LAMP_FLOAT_DW-1:0]   res_o,
  output logic [2:0]                 flags_o,
  input  logic                       clr_flags_i,
  output logic [2:0]                 fflags_o
);

  localparam int E = LAMP_FLOAT_E_DW;
  localparam int F = LAMP_FLOAT_F_DW;

  logic                 s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  rndStage_t            s1_q, s1_d;
  logic [LAMP_FLOAT_DW-1:0] s2_res_q, s2_res_d;
  logic [2:0]           s2_flags_q, s2_flags_d;
  logic                 s1_en, s2_en;

  logic [F+1:0]         m_sum;
  logic [E:0]           e_sum;
  logic [F-1:0]         frac;
  logic [LAMP_FLOAT_DW-1:0] res;
  logic [2:0]           flags;

  // Handshake enables and S1 rounding decision
  always_comb begin
    s2_en  = ~s2_v_q | ready_i;
    s1_en  = ~s1_v_q | s2_en;
    s1_v_d = s1_en ? valid_i : s1_v_q;
    s2_v_d = s2_en ? s1_v_q : s2_v_q;
    s1_d   = s1_q;
    if (s1_en && valid_i) begin
      s1_d.s     = s_i;
      s1_d.e     = e_i;
      s1_d.m     = f_i[F+4:4];
      s1_d.inc   = isToRound_i & FUNC_rndRNE(f_i[4], f_i[3], |f_i[2:0]);
      s1_d.nx    = isToRound_i & (f_i[3] | (|f_i[2:0]));
      s1_d.of    = isOverflow_i;
      s1_d.uf    = isUnderflow_i;
      s1_d.toRnd = isToRound_i;
    end
  end

  // S2: apply increment, fold mantissa carry into exponent, saturate to Inf
  always_comb begin
    m_sum = {1'b0, s1_q.m} + {{(F+1){1'b0}}, s1_q.inc};
    e_sum = {1'b0, s1_q.e} + {{E{1'b0}}, m_sum[F+1]};
    frac  = m_sum[F+1] ? '0 : m_sum[F-1:0];
    flags = '0;
    if (s1_q.toRnd) begin
      if (e_sum >= {1'b0, {E{1'b1}}}) begin
        res                = {s1_q.s, {E{1'b1}}, {F{1'b0}}};
        flags[FLAG_OF_IDX] = 1'b1;
        flags[FLAG_NX_IDX] = 1'b1;
      end else begin
        res                = {s1_q.s, e_sum[E-1:0], frac};
        flags[FLAG_OF_IDX] = s1_q.of;
        flags[FLAG_NX_IDX] = s1_q.nx;
      end
      flags[FLAG_UF_IDX] = s1_q.uf & flags[FLAG_NX_IDX];
    end else begin
      // NaN / Inf / zero travel through untouched and raise nothing
      res = {s1_q.s, s1_q.e, s1_q.m[F-1:0]};
    end
    s2_res_d   = (s2_en && s1_v_q) ? res   : s2_res_q;
    s2_flags_d = (s2_en && s1_v_q) ? flags : s2_flags_q;
  end

  // Pipeline state; reset discards anything in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      s1_q       <= '0;
      s2_res_q   <= '0;
      s2_flags_q <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s2_v_q     <= s2_v_d;
      s1_q       <= s1_d;
      s2_res_q   <= s2_res_d;
      s2_flags_q <= s2_flags_d;
    end
  end

  assign ready_o = s1_en;
  assign valid_o = s2_v_q;
  assign res_o   = s2_res_q;
  assign flags_o = s2_flags_q;

`ifdef LAMP_FPU_FLAGS_EN
  logic [2:0] fflags_q, fflags_d;

  // Sticky flags: a coinciding clear keeps only the flags of that transfer
  always_comb begin
    fflags_d = clr_flags_i ? 3'b000 : fflags_q;
    if (valid_o && ready_i) fflags_d = fflags_d | flags_o;
  end

  // Sticky flag register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fflags_q <= '0;
    else      fflags_q <= fflags_d;
  end

  assign fflags_o = fflags_q;
`else
  logic unused_clr;
  assign unused_clr = clr_flags_i;
  assign fflags_o   = 3'b000;
`endif

endmodule

// File: tb/tb_lampfpu_sqrt_rnd.sv
// Directed bench for lampfpu_sqrt_rnd (round/pack, handshake, stall, reset).
module tb_lampfpu_sqrt_rnd;
  import lampfpu_sqrt_rnd_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_i = 1'b0, ready_i = 1'b1;
  logic        ready_o, valid_o;
  logic        s_i = 1'b0;
  logic [7:0]  e_i = '0;
  logic [11:0] f_i = '0;
  logic        to_rnd = 1'b0, of_i = 1'b0, uf_i = 1'b0, clr_flags_i = 1'b0;
  logic [15:0] res_o;
  logic [2:0]  flags_o, fflags_o;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  lampfpu_sqrt_rnd dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .s_i(s_i), .e_i(e_i), .f_i(f_i), .isToRound_i(to_rnd),
    .isOverflow_i(of_i), .isUnderflow_i(uf_i),
    .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o), .flags_o(flags_o),
    .clr_flags_i(clr_flags_i), .fflags_o(fflags_o)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic [7:0] e, input logic [11:0] f,
                       input logic tr, input logic o, input logic u);
    s_i = s; e_i = e; f_i = f; to_rnd = tr; of_i = o; uf_i = u; valid_i = 1'b1;
  endtask

  // One unstalled transaction: must show up exactly two edges after accept
  task automatic run1(input string tag, input logic s, input logic [7:0] e, input logic [11:0] f,
                      input logic tr, input logic o, input logic u,
                      input logic [15:0] eres, input logic [2:0] efl);
    @(negedge clk);
    drive(s, e, f, tr, o, u);
    #1 chk({tag, "_rdy"}, ready_o, 1);
    @(posedge clk); #1 valid_i = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, valid_o, 0);
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_vld"}, valid_o, 1);
    chk({tag, "_res"}, res_o, eres);
    chk({tag, "_flg"}, flags_o, efl);
  endtask

  logic [11:0] vf [3];
  logic [7:0]  ve [3];
  logic        vt [3];
  logic [15:0] vr [3];
  int idx, got, accepted_stalled;
  logic [15:0] held;

  initial begin
    vf[0] = 12'b1_0000000_0000; ve[0] = 8'h80; vt[0] = 1'b1; vr[0] = 16'h4000;
    vf[1] = 12'b1_0000001_1000; ve[1] = 8'h7F; vt[1] = 1'b1; vr[1] = 16'h3F82;
    vf[2] = 12'b1_1000000_0000; ve[2] = 8'hFF; vt[2] = 1'b0; vr[2] = 16'h7FC0;

    #12;
    chk("rst_vld", valid_o, 0);
    chk("rst_res", res_o, 0);
    chk("rst_flg", flags_o, 0);
    chk("rst_fflg", fflags_o, 0);
    @(negedge clk) rst = 1'b1;

    run1("exact",    0, 8'h80, 12'b1_0000000_0000, 1, 0, 0, 16'h4000, 3'b000);
    run1("tie_odd",  0, 8'h7F, 12'b1_0000001_1000, 1, 0, 0, 16'h3F82, 3'b001);
    run1("tie_even", 0, 8'h7F, 12'b1_0000000_1000, 1, 0, 0, 16'h3F80, 3'b001);
`ifdef LAMP_FPU_FLAGS_EN
    @(negedge clk);
    chk("fflg_acc", fflags_o, 3'b001);
    clr_flags_i = 1'b1;
    @(negedge clk);
    clr_flags_i = 1'b0;
    chk("fflg_clr", fflags_o, 3'b000);
`endif
    run1("carry",    0, 8'h7F, 12'b1_1111111_1001, 1, 0, 0, 16'h4000, 3'b001);
    run1("ovf_inf",  0, 8'hFE, 12'b1_1111111_1001, 1, 0, 0, 16'h7F80, 3'b101);
    run1("qnan",     0, 8'hFF, 12'b1_1000000_0000, 0, 0, 0, 16'h7FC0, 3'b000);
    run1("uf_nx",    1, 8'h01, 12'b1_0000000_0100, 1, 0, 1, 16'h8080, 3'b011);
    run1("uf_exact", 0, 8'h80, 12'b1_0000000_0000, 1, 0, 1, 16'h4000, 3'b000);
    run1("of_pass",  0, 8'h80, 12'b1_0000000_0000, 1, 1, 0, 16'h4000, 3'b100);
    run1("nospec",   1, 8'hFF, 12'b1_1111111_1111, 0, 1, 1, 16'hFFFF, 3'b000);

    // Stall: ready_i low for four cycles while three inputs are offered
    idx = 0; got = 0; accepted_stalled = 0; held = '0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      ready_i = (cyc >= 4);
      if (idx < 3) drive(0, ve[idx], vf[idx], vt[idx], 0, 0);
      else valid_i = 1'b0;
      #1;
      if (valid_o && ready_i) begin
        if (got < 3) chk($sformatf("stall_ord%0d", got), res_o, vr[got]);
        got++;
      end
      if (cyc == 2) begin
        chk("stall_rdy_drop", ready_o, 0);
        chk("stall_accepts", idx, 2);
        chk("stall_vld", valid_o, 1);
        held = res_o;
      end
      if (cyc == 3) begin
        chk("stall_hold_vld", valid_o, 1);
        chk("stall_hold_res", res_o, held);
      end
      @(posedge clk);
      if (valid_i && ready_o) idx++;
    end
    valid_i = 1'b0;
    chk("stall_count", got, 3);
    chk("stall_in_count", idx, 3);

    // Reset with both stages full
    @(negedge clk);
    ready_i = 1'b0;
    drive(0, 8'h7F, 12'b1_0000001_1000, 1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 8'h80, 12'b1_0000000_0000, 1, 0, 0);
    @(posedge clk); #1 valid_i = 1'b0;
    @(negedge clk);
    chk("pre_rst_vld", valid_o, 1);
    rst = 1'b0;
    #1;
    chk("rst_async_vld", valid_o, 0);
    chk("rst_async_res", res_o, 0);
    @(negedge clk);
    rst = 1'b1; ready_i = 1'b1;
    chk("post_rst_fflg", fflags_o, 0);
    run1("post_rst", 0, 8'h7F, 12'b1_0000000_1000, 1, 0, 0, 16'h3F80, 3'b001);
    @(negedge clk);
`ifdef LAMP_FPU_FLAGS_EN
    chk("fflg_final", fflags_o, 3'b001);
`else
    chk("fflg_off", fflags_o, 3'b000);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
